led_share_arbiter: RTL and testbench
====================================

Name: led_share_arbiter

Overview:
- Shares the single 3-bit active-low RGB LED between four requesters (status sources elsewhere on the board).
- Round-robin arbitration; each owner holds the LED for a time-sliced slot, timed by an internal tick prescaler.
- A one-cycle blank gap separates owners.
- The `led` output drives the board LED pins directly. LED code is 110 G, 101 R, 011 B, 111 off.

Parameters:
- TICK_DIV, 24_000, sys_clk cycles per tick (1 ms at 24 MHz); legal range ≥2.
- SLOT_TICKS, 500, ticks per ownership slot (0.5 s); legal range ≥1.
- BLINK_TICKS, 125, ticks per blink half-period; used only with LED_SHARE_BLINK_EN.

Ports:
- sys_clk  in  1  system clock, 24 MHz.
- sys_rst_n  in  1  reset; synchronous, active-low.
- req  in  4  request; req[i] high = requester i wants the LED.
- color  in  12  active-low LED code for requester i on color[3i+2:3i].
- blink  in  4  per-requester blink select; ignored without LED_SHARE_BLINK_EN.
- grant  out  4  one-hot owner indication, zero when no owner.
- busy  out  1  high in ARB or HOLD.
- led  out  3  active-low RGB drive.

Behaviour:
- All outputs are registered. State register `state`: IDLE, ARB, HOLD.
- Reset (sys_rst_n low at a rising edge) forces:
  - state=IDLE, led=3'b111, grant=4'b0000, busy=0;
  - last=3 (so requester 0 has first priority); tick_cnt, slot_cnt and blink phase cleared.
  - Reset mid-HOLD or mid-ARB aborts immediately; there is no completion of the slot.
- IDLE: led=111, grant=0, busy=0. If any req bit is high at an edge, go to ARB.
- ARB (exactly 1 cycle): led=111, grant=0, busy=1.
  - Winner = first set req bit searching last+1, last+2, last+3, last (mod 4).
  - If the winner exists: next state HOLD, grant=onehot(winner), last=winner, color latched from color[winner], tick_cnt=0, slot_cnt=0.
  - If req dropped to 0: go to IDLE.
- Latency: req rising sampled at edge N (IDLE) gives ARB at N+1 and grant/led valid at N+2.
- HOLD: led = latched color; changes on the color input during HOLD are ignored.
  - tick_cnt counts 0..TICK_DIV-1 and wraps; tick = (tick_cnt==TICK_DIV-1).
  - slot_cnt increments on each tick.
  - Slot expiry = tick with slot_cnt==SLOT_TICKS-1. Slot length is exactly TICK_DIV*SLOT_TICKS cycles.
- HOLD exit conditions:
  - Early release: req[owner] low at an edge leaves HOLD at that edge.
  - Release and expiry on the same edge are treated as one exit.
  - On exit: next state ARB if any req bit is high, else IDLE; grant cleared at the same edge.
- A lone persistent requester is re-granted after each 1-cycle ARB gap.
- Counter widths use $clog2 of the respective parameter; no overflow past the terminal value.

Optional Feature:
- Macro: LED_SHARE_BLINK_EN.
- Defined:
  - In HOLD with blink[owner] sampled high at grant, led alternates latched color / 111, starting with color.
  - Phase toggles every BLINK_TICKS ticks; phase resets at each grant.
  - blink[owner] low → steady color.
- Undefined: the blink port is ignored and no blink counter is synthesised; led is steady color for the whole HOLD.

Test Plan:
(Bench parameters: TICK_DIV=4, SLOT_TICKS=3, BLINK_TICKS=1.)
1. sys_rst_n=0 for 2 edges with req=4'b1111 → led=111, grant=0000, busy=0. Release reset with req=0001 → at the first edge after release, busy=1 with grant still 0000 (ARB); at the following edge, grant=0001.
2. req=0001 from edge N, color[2:0]=110 → N+1 led=111, busy=1; N+2..N+13 grant=0001, led=110 (12 cycles); N+14 ARB gap; N+15 regranted.
3. req=0101 steady, color0=110, color2=011 → grant sequence 0001, gap, 0100, gap, 0001…; each slot 12 cycles; req bits 1 and 3 are never granted.
4. req0 only, drop req[0] on the 5th cycle of HOLD → at that edge grant=0000, led=111, state=IDLE, busy=0. Repeat with req=0011 → ARB then grant=0010.
5. Change color0 from 110 to 101 mid-slot → led stays 110 until the slot ends; the next grant shows 101.
6. Assert reset during HOLD with owner 2 → next edge sees reset outputs. Release with req=0101 → requester 0 is granted first (last reset to 3).

Source files
------------

// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin time-sliced sharing of one active-low RGB LED among four requesters; LED_SHARE_BLINK_EN enables per-owner blinking
module led_share_arbiter #(
  parameter int TICK_DIV    = 24_000,
  parameter int SLOT_TICKS  = 500,
  parameter int BLINK_TICKS = 125
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  req,
  input  logic [11:0] color,
  input  logic [3:0]  blink,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [2:0]  led
);
  localparam int tw = $clog2(TICK_DIV);
  localparam int sw = SLOT_TICKS > 1 ? $clog2(SLOT_TICKS) : 1;
  localparam logic [tw-1:0] tick_max = tw'(TICK_DIV - 1);
  localparam logic [sw-1:0] slot_max = sw'(SLOT_TICKS - 1);
  typedef enum logic [1:0] {IDLE, ARB, HOLD} state_t;
  state_t state, state_n;
  logic [1:0] last, last_n, win, idx;
  logic found, tick, expire, leave;
  logic [tw-1:0] tick_cnt, tick_cnt_n;
  logic [sw-1:0] slot_cnt, slot_cnt_n;
  logic [2:0] col, col_n, led_n;
  logic [3:0] grant_n;
  always_comb begin
    found = 1'b0;
    win = last;
    idx = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign tick = tick_cnt == tick_max;
  assign expire = tick && slot_cnt == slot_max;
  assign leave = !req[last] || expire;
  always_comb begin
    state_n = state;
    last_n = last;
    col_n = col;
    grant_n = 4'b0000;
    tick_cnt_n = '0;
    slot_cnt_n = '0;
    if (state == IDLE) begin
      state_n = |req ? ARB : IDLE;
    end else if (state == ARB) begin
      state_n = found ? HOLD : IDLE;
      if (found) begin
        last_n = win;
        col_n = color[3*win +: 3];
        grant_n = 4'b0001 << win;
      end
    end else begin
      state_n = leave ? (|req ? ARB : IDLE) : HOLD;
      if (!leave) begin
        grant_n = grant;
        tick_cnt_n = tick ? '0 : tick_cnt + 1'b1;
        slot_cnt_n = tick ? slot_cnt + 1'b1 : slot_cnt;
      end
    end
  end
`ifdef LED_SHARE_BLINK_EN
  localparam int bw = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  localparam logic [bw-1:0] blink_max = bw'(BLINK_TICKS - 1);
  logic blk, blk_n, ph, ph_n;
  logic [bw-1:0] blink_cnt, blink_cnt_n;
  always_comb begin
    blk_n = blk;
    ph_n = ph;
    blink_cnt_n = blink_cnt;
    if (state == ARB) begin
      blk_n = blink[win];
      ph_n = 1'b0;
      blink_cnt_n = '0;
    end else if (state == HOLD && tick) begin
      ph_n = blink_cnt == blink_max ? !ph : ph;
      blink_cnt_n = blink_cnt == blink_max ? '0 : blink_cnt + 1'b1;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      blk <= 1'b0;
      ph <= 1'b0;
      blink_cnt <= '0;
    end else begin
      blk <= blk_n;
      ph <= ph_n;
      blink_cnt <= blink_cnt_n;
    end
  end
  assign led_n = |grant_n ? ((blk_n && ph_n) ? 3'b111 : col_n) : 3'b111;
`else
  logic unused_blink;
  assign unused_blink = ^blink;
  assign led_n = |grant_n ? col_n : 3'b111;
`endif
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      last <= 2'd3;
      col <= 3'b111;
      tick_cnt <= '0;
      slot_cnt <= '0;
      grant <= 4'b0000;
      busy <= 1'b0;
      led <= 3'b111;
    end else begin
      state <= state_n;
      last <= last_n;
      col <= col_n;
      tick_cnt <= tick_cnt_n;
      slot_cnt <= slot_cnt_n;
      grant <= grant_n;
      busy <= state_n != IDLE;
      led <= led_n;
    end
  end
endmodule

// File: tb/tb_led_share_arbiter.sv
// tb_led_share_arbiter: directed vector table plus hand sequences for slot timing, color latching and reset abort
module tb_led_share_arbiter;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [11:0] color = 12'hFFF;
  logic [3:0] blink = 4'b0000;
  logic [3:0] grant;
  logic busy;
  logic [2:0] led;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic rst_n;
    logic [3:0] req;
    logic [11:0] color;
    logic [3:0] g;
    logic b;
    logic [2:0] l;
  } vec_t;
  vec_t tbl[$];
  led_share_arbiter #(.TICK_DIV(4), .SLOT_TICKS(3), .BLINK_TICKS(1)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req), .color(color),
    .blink(blink), .grant(grant), .busy(busy), .led(led)
  );
  always #5 sys_clk = ~sys_clk;
  function automatic vec_t v(logic r, logic [3:0] q, logic [11:0] c, logic [3:0] g, logic b, logic [2:0] l);
    vec_t t;
    t.rst_n = r; t.req = q; t.color = c; t.g = g; t.b = b; t.l = l;
    return t;
  endfunction
  task automatic cyc(input logic r, input logic [3:0] q, input logic [11:0] c,
                     input logic [3:0] g, input logic b, input logic [2:0] l, input string name);
    sys_rst_n = r;
    req = q;
    color = c;
    @(posedge sys_clk);
    #1;
    n_cmp++;
    if (grant !== g || busy !== b || led !== l) begin
      n_bad++;
      $display("FAIL %s: got grant=%b busy=%b led=%b, want grant=%b busy=%b led=%b",
               name, grant, busy, led, g, b, l);
    end
  endtask
  initial begin
    // color word FEE: requester0=110, requester1=101; EFE: requester0=110, requester2=011
    tbl.push_back(v(0, 4'hF, 12'hFEE, 4'h0, 0, 3'b111));
    tbl.push_back(v(0, 4'hF, 12'hFEE, 4'h0, 0, 3'b111));
    tbl.push_back(v(1, 4'h1, 12'hFEE, 4'h0, 1, 3'b111));
    for (int i = 0; i < 12; i++) tbl.push_back(v(1, 4'h1, 12'hFEE, 4'h1, 1, 3'b110));
    tbl.push_back(v(1, 4'h1, 12'hFEE, 4'h0, 1, 3'b111));
    tbl.push_back(v(1, 4'h1, 12'hFEE, 4'h1, 1, 3'b110));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 4'h1, 12'hFEE, 4'h1, 1, 3'b110));
    tbl.push_back(v(1, 4'h0, 12'hFEE, 4'h0, 0, 3'b111));
    tbl.push_back(v(1, 4'h3, 12'hFEE, 4'h0, 1, 3'b111));
    tbl.push_back(v(1, 4'h3, 12'hFEE, 4'h2, 1, 3'b101));
    tbl.push_back(v(1, 4'h0, 12'hFEE, 4'h0, 0, 3'b111));
    tbl.push_back(v(1, 4'h0, 12'hFEE, 4'h0, 0, 3'b111));
    @(posedge sys_clk);
    #1;
    foreach (tbl[i]) cyc(tbl[i].rst_n, tbl[i].req, tbl[i].color, tbl[i].g, tbl[i].b, tbl[i].l, $sformatf("tbl[%0d]", i));
    cyc(1, 4'h1, 12'hFEE, 4'h0, 1, 3'b111, "latch_arb");
    cyc(1, 4'h1, 12'hFEE, 4'h1, 1, 3'b110, "latch_grant");
    for (int k = 1; k <= 11; k++)
      cyc(1, 4'h1, k < 4 ? 12'hFEE : 12'hFED, 4'h1, 1, 3'b110, $sformatf("latch_hold%0d", k));
    cyc(1, 4'h1, 12'hFED, 4'h0, 1, 3'b111, "latch_gap");
    cyc(1, 4'h1, 12'hFED, 4'h1, 1, 3'b101, "latch_new_color");
    cyc(1, 4'h4, 12'hEFE, 4'h0, 1, 3'b111, "own2_arb");
    cyc(1, 4'h4, 12'hEFE, 4'h4, 1, 3'b011, "own2_grant");
    cyc(1, 4'h4, 12'hEFE, 4'h4, 1, 3'b011, "own2_hold1");
    cyc(1, 4'h4, 12'hEFE, 4'h4, 1, 3'b011, "own2_hold2");
    cyc(0, 4'h5, 12'hEFE, 4'h0, 0, 3'b111, "rst_abort");
    cyc(0, 4'h5, 12'hEFE, 4'h0, 0, 3'b111, "rst_hold");
    cyc(1, 4'h5, 12'hEFE, 4'h0, 1, 3'b111, "rr_arb");
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 12; k++)
        cyc(1, 4'h5, 12'hEFE, s % 2 ? 4'h4 : 4'h1, 1, s % 2 ? 3'b011 : 3'b110, $sformatf("rr_slot%0d_c%0d", s, k));
      cyc(1, 4'h5, 12'hEFE, 4'h0, 1, 3'b111, $sformatf("rr_gap%0d", s));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
